// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receive path.
//   - Prefix bytes (extended, break, pause) that steer the decoder FSM.
//   - Keyboard response codes that never represent a key.
//   - Fake-shift codes that some keyboards insert around E0 sequences.
//   - Decoder state encoding and small byte-classification helpers.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVRFF  = 8'hFF;

    localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

    // Number of bytes that follow E1 in the Pause make sequence.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StPause
    } dec_state_e;

    function automatic logic is_response(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_OVR0) || (b == PS2_OVRFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: PS/2 line receiver. Synchronizes and filters the raw PS/2 lines,
// assembles 11-bit frames into bytes and checks parity, stop bit and timeout.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2clk_in           raw PS/2 clock (asynchronous)
//   ps2data_in          raw PS/2 data (asynchronous)
//   byte_valid          one-cycle strobe, data_byte holds a good byte
//   data_byte[7:0]      last received byte
//   frame_error         one-cycle strobe on parity, stop-bit or timeout error
module ps2_rx_byte #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 28000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_error
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic [FILTER_LEN-1:0] filt_hist_q;
    logic                  filt_clk_q;
    logic                  fall;
    logic                  data_s;

    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    assign data_s = data_sync_q[1];
    // The filtered clock is about to drop: this is the sampling instant.
    assign fall   = filt_clk_q && (filt_hist_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_hist_q <= '1;
            filt_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2clk_in};
            data_sync_q <= {data_sync_q[0], ps2data_in};
            filt_hist_q <= {filt_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            if (&filt_hist_q) begin
                filt_clk_q <= 1'b1;
            end else if (filt_hist_q == '0) begin
                filt_clk_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timer_d   = timer_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        if (fall) begin
            // An edge always beats a timeout expiring in the same cycle.
            timer_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high start bit is noise: ignore it without flagging.
                if (!data_s) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                parity_d  = data_s;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if (data_s && (^shift_q ^ parity_q)) begin
                    valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                timer_d   = '0;
                bit_cnt_d = 4'd0;
                error_d   = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign byte_valid  = valid_q;
    assign data_byte   = shift_q;
    assign frame_error = error_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns raw PS/2 keyboard traffic into key events.
// Strips E0 / F0 / E1 prefixes and delivers one event per key.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2clk_in       raw PS/2 clock (asynchronous)
//   ps2data_in      raw PS/2 data (asynchronous)
//   scan_received   one-cycle strobe: new key event
//   scancode[7:0]   event scancode, held until the next event
//   extended        event was E0-prefixed, held
//   released        event was F0-prefixed (break), held
//   pause_pressed   one-cycle strobe after a full E1 Pause sequence
//   rx_error        one-cycle strobe on parity, stop-bit or timeout error
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 28000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       scan_received,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       pause_pressed,
    output logic       rx_error
);

    logic       byte_valid;
    logic [7:0] rx_data;
    logic       frame_error;

    ps2_rx_byte #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2clk_in   (ps2clk_in),
        .ps2data_in  (ps2data_in),
        .byte_valid  (byte_valid),
        .data_byte   (rx_data),
        .frame_error (frame_error)
    );

    dec_state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       emit, emit_ext, emit_rel, pause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        pause_d  = 1'b0;
        if (frame_error) begin
            state_d = StIdle;
        end else if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == PS2_EXT) begin
                        state_d = StExt;
                    end else if (rx_data == PS2_BRK) begin
                        state_d = StBrk;
                    end else if (rx_data == PS2_PAUSE) begin
                        state_d = StPause;
                        skip_d  = PS2_PAUSE_SKIP;
                    end else if (!is_response(rx_data)) begin
                        emit = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_data == PS2_BRK) begin
                        state_d = StExtBrk;
                    end else begin
                        state_d  = StIdle;
                        emit     = !is_fake_shift(rx_data);
                        emit_ext = 1'b1;
                    end
                end
                StBrk: begin
                    state_d  = StIdle;
                    emit     = 1'b1;
                    emit_rel = 1'b1;
                end
                StExtBrk: begin
                    state_d  = StIdle;
                    emit     = !is_fake_shift(rx_data);
                    emit_ext = 1'b1;
                    emit_rel = 1'b1;
                end
                StPause: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        pause_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_received <= 1'b0;
            scancode      <= 8'h00;
            extended      <= 1'b0;
            released      <= 1'b0;
            pause_pressed <= 1'b0;
        end else begin
            scan_received <= emit;
            pause_pressed <= pause_d;
            if (emit) begin
                scancode <= rx_data;
                extended <= emit_ext;
                released <= emit_rel;
            end
        end
    end

    assign rx_error = frame_error;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed bench for the PS/2 scancode decoder.
// Uses a shortened filter/timeout and a fast PS/2 clock so whole byte
// sequences fit in a short run; expected values are hand-computed.
module tb_ps2_scancode_decoder;

    localparam int unsigned FiltLen = 4;
    localparam int unsigned Tmo     = 400;
    localparam int          Half    = 20;   // PS/2 half period in clk cycles
    localparam int          Gap     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       scan_received;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       pause_pressed;
    logic       rx_error;

    int n_cmp = 0;
    int n_bad = 0;
    int n_scan = 0;
    int n_pause = 0;
    int n_err = 0;
    int s0, p0, e0;

    ps2_scancode_decoder #(
        .FILTER_LEN     (FiltLen),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2clk_in     (ps2clk),
        .ps2data_in    (ps2data),
        .scan_received (scan_received),
        .scancode      (scancode),
        .extended      (extended),
        .released      (released),
        .pause_pressed (pause_pressed),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    // Count strobe-high cycles; a stuck strobe inflates the count.
    always @(negedge clk) begin
        if (scan_received) n_scan++;
        if (pause_pressed) n_pause++;
        if (rx_error) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2data = frame[i];
            wait_cyc(Half);
            ps2clk = 1'b0;
            wait_cyc(Half);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
        wait_cyc(Gap);
    endtask

    task automatic snap();
        s0 = n_scan;
        p0 = n_pause;
        e0 = n_err;
    endtask

    initial begin
        wait_cyc(5);
        rst = 1'b0;
        @(negedge clk);
        check("rst_scan", {31'd0, scan_received}, 32'd0);
        check("rst_code", {24'd0, scancode}, 32'h00);
        check("rst_ext", {31'd0, extended}, 32'd0);
        check("rst_rel", {31'd0, released}, 32'd0);
        check("rst_pause", {31'd0, pause_pressed}, 32'd0);
        check("rst_err", {31'd0, rx_error}, 32'd0);

        // Plain make code.
        snap();
        send_byte(8'h1C, 1'b0);
        check("mk_cnt", n_scan - s0, 32'd1);
        check("mk_code", {24'd0, scancode}, 32'h1C);
        check("mk_ext", {31'd0, extended}, 32'd0);
        check("mk_rel", {31'd0, released}, 32'd0);
        check("mk_err", n_err - e0, 32'd0);

        // Break: no event on F0, one on the key byte.
        snap();
        send_byte(8'hF0, 1'b0);
        check("brk_f0_cnt", n_scan - s0, 32'd0);
        send_byte(8'h1C, 1'b0);
        check("brk_cnt", n_scan - s0, 32'd1);
        check("brk_code", {24'd0, scancode}, 32'h1C);
        check("brk_rel", {31'd0, released}, 32'd1);
        check("brk_ext", {31'd0, extended}, 32'd0);

        // Extended break, then a fake shift that must be swallowed.
        snap();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("xbrk_cnt", n_scan - s0, 32'd1);
        check("xbrk_code", {24'd0, scancode}, 32'h75);
        check("xbrk_ext", {31'd0, extended}, 32'd1);
        check("xbrk_rel", {31'd0, released}, 32'd1);
        snap();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h12, 1'b0);
        check("fake_cnt", n_scan - s0, 32'd0);
        check("fake_hold", {24'd0, scancode}, 32'h75);

        // Parity error after an E0 prefix clears the prefix.
        snap();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b1);
        check("par_err", n_err - e0, 32'd1);
        check("par_scan", n_scan - s0, 32'd0);
        send_byte(8'h1C, 1'b0);
        check("par_next_cnt", n_scan - s0, 32'd1);
        check("par_next_ext", {31'd0, extended}, 32'd0);
        check("par_next_rel", {31'd0, released}, 32'd0);

        // Timeout: stall after 4 bits.
        snap();
        send_bits(11'b1_0_00011100_0, 4);
        wait_cyc(Tmo + 100);
        check("tmo_err", n_err - e0, 32'd1);
        check("tmo_bitcnt", {28'd0, dut.u_rx.bit_cnt_q}, 32'd0);
        check("tmo_scan", n_scan - s0, 32'd0);
        send_byte(8'h1C, 1'b0);
        check("tmo_next_cnt", n_scan - s0, 32'd1);
        check("tmo_next_code", {24'd0, scancode}, 32'h1C);
        check("tmo_err_total", n_err - e0, 32'd1);

        // Pause sequence; an ACK afterwards is filtered.
        snap();
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("pse_early", n_pause - p0, 32'd0);
        send_byte(8'h77, 1'b0);
        check("pse_cnt", n_pause - p0, 32'd1);
        send_byte(8'hFA, 1'b0);
        check("pse_scan", n_scan - s0, 32'd0);
        check("pse_after", n_pause - p0, 32'd1);

        // Reset mid-sequence: the next E1 restarts the skip count.
        snap();
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        check("rstm_code", {24'd0, scancode}, 32'h00);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        check("rstm_early", n_pause - p0, 32'd0);
        send_byte(8'h77, 1'b0);
        check("rstm_pause", n_pause - p0, 32'd1);
        check("rstm_scan", n_scan - s0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Front end of the keyboard path: receives raw PS/2 clock/data from the keyboard port and assembles 11-bit frames into bytes.
- Strips the E0/F0/E1 prefix protocol and delivers one event per key (scancode + extended + released, 1-cycle strobe).
- Feeds the scancode-to-matrix translator, the pressed-status tracker and the special-function decoder directly, all on the same clk.

Parameters:
- FILTER_LEN, 8, consecutive equal samples required before the filtered PS/2 clock changes level (range 2..16).
- TIMEOUT_CYCLES, 28000, clk cycles without a falling edge mid-frame before the frame is aborted (~1 ms at 28 MHz).

Ports:
- clk  input  1  system clock, same clock as all keyboard consumers
- rst  input  1  synchronous, active-high reset
- ps2clk_in  input  1  raw PS/2 clock, asynchronous
- ps2data_in  input  1  raw PS/2 data, asynchronous
- scan_received  output  1  one-cycle strobe: new key event valid
- scancode  output  8  scancode of the event, held until the next event
- extended  output  1  event was E0-prefixed, held
- released  output  1  event was F0-prefixed (break), held
- pause_pressed  output  1  one-cycle strobe when a complete E1 Pause sequence is consumed
- rx_error  output  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs reset to 0.
  - Filter history resets to all-ones, filtered clock to 1.
  - Bit counter resets to 0; decoder FSM resets to IDLE.
  - Reset mid-frame discards the partial frame and any pending prefix.
- Input conditioning:
  - Both raw inputs pass through 2-FF synchronizers.
  - ps2clk goes through a FILTER_LEN shift register; the filtered level changes only when all entries agree.
  - A falling edge of the filtered clock samples synchronized data.
- Frame receive (sub-module):
  - Bit 0 is the start bit and must be 0; if it is 1, drop it silently and keep the counter at 0 (no error).
  - Bits 1..8 are data, LSB first. Bit 9 is odd parity. Bit 10 is the stop bit and must be 1.
  - On the stop-bit edge: if parity and stop are good, byte_valid pulses in the next cycle; otherwise rx_error pulses in the next cycle and the byte is discarded.
  - Timeout counter:
    - Runs while the bit counter is nonzero and clears on every falling edge.
    - Reaching TIMEOUT_CYCLES resets the bit counter to 0 and pulses rx_error.
    - It is idle at counter 0.
- Decoder FSM, stepping on byte_valid:
  - IDLE
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip count 7.
    - FA/AA/EE/FE/00/FF are filtered (no event).
    - Any other byte emits an event with ext=0, rel=0.
  - EXT
    - F0 -> EXTBRK.
    - 12 or 59 (fake shift) -> IDLE, no event.
    - Other bytes emit an event with ext=1, rel=0, then -> IDLE.
  - BRK: the byte emits an event with ext=0, rel=1, then -> IDLE.
  - EXTBRK
    - 12 or 59 -> IDLE, no event.
    - Other bytes emit an event with ext=1, rel=1, then -> IDLE.
  - PAUSE: each byte decrements the skip count. When the count reaches 0, pause_pressed pulses and the FSM goes to IDLE. No scan events are emitted during PAUSE.
  - Any rx_error forces the FSM to IDLE (prefix discarded).
- Event output:
  - scancode, extended and released update and scan_received pulses in the cycle after byte_valid.
  - Total latency is 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
- Simultaneous events: byte_valid and rx_error are mutually exclusive by construction. A timeout expiring in the same cycle as a falling edge loses to the edge.
- Between events, scan_received stays 0 and the held outputs do not change.

Decomposition:
- Shared package ps2_pkg holds:
  - Prefix constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - Response codes: FA/AA/EE/FE/00/FF.
  - Fake-shift codes: 12/59.
  - Decoder state encoding.
- Sub-module ps2_rx_byte covers the synchronizers, filter, frame shift register, parity/stop check and timeout. Its outputs are byte_valid, byte[7:0] and frame_error.
- The prefix FSM and output registers live in the top module.

Test Plan:
- Frame 0x1C (parity 0) at a 12 kHz PS/2 clock -> one scan_received pulse; scancode=1C, extended=0, released=0.
- Bytes F0,1C -> exactly one pulse, on the second byte: scancode=1C, released=1, extended=0. No pulse after F0.
- Bytes E0,F0,75 -> one pulse: scancode=75, extended=1, released=1. Then E0,12 -> no pulse.
- Byte 1C sent with the parity bit inverted -> rx_error pulses once, no scan_received. The following 1C is received normally with extended/released=0 (prefix state cleared).
- Stop the clock after 4 bits for more than TIMEOUT_CYCLES -> rx_error pulses once and the bit counter returns to 0. The next full 0x1C frame decodes correctly.
- Bytes E1,14,77,E1,F0,14,F0,77 then FA -> one pause_pressed pulse on the 8th byte and zero scan_received pulses. Assert rst between bytes 3 and 4 -> FSM is IDLE, so byte 4 (E1) restarts PAUSE.
